// File: rtl/adder_pkg.sv
// Shared constants and types for the modulo (2^N - K) adder.
// Default width and correction constant, derived modulus, and a mod-M reference sum.
package adder_pkg;

    localparam int DEF_N = 7;
    localparam int DEF_K = 104;
    localparam int DEF_M = (1 << DEF_N) - DEF_K;

    typedef logic [DEF_N-1:0] word_t;

    function automatic int mod_sum(input int a, input int b, input int m);
        return (a + b) % m;
    endfunction

endpackage

// File: rtl/sum_xor_unit.sv
// Forms a sum from a half-sum and its prefix carries: h ^ (carry << 1).
// Combinational, zero latency, no flow control.
module sum_xor_unit #(
    parameter int N = adder_pkg::DEF_N
) (
    input  logic [N-1:0] h,
    input  logic [N-1:0] c,
    output logic [N-1:0] s
);

    // The carry out of the top bit falls off the shift: arithmetic is modulo 2^N.
    assign s = h ^ (c << 1);

endmodule

// File: rtl/modular_sum_stage.sv
// Final stage of the mod (2^N - K) adder: picks plain or primed sum and flags results >= M.
// Latency 2 cycles, 1 result/cycle; two-deep pipeline, bubbles collapse.
// Backpressure: in_ready = !vA | !out_valid | out_ready; stalled output is held stable.
module modular_sum_stage
    import adder_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] h,
    input  logic [N-1:0] c,
    input  logic [N-1:0] h_prim,
    input  logic [N-1:0] c_prim,
    input  logic         ovf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         out_range_err
);

    localparam logic [N-1:0] MOD = N'((1 << N) - K);

    logic [N-1:0] s_plain;
    logic [N-1:0] s_prim;
    logic         sel;

    logic [N-1:0] a_plain;
    logic [N-1:0] a_prim;
    logic         a_sel;
    logic         va;
    logic [N-1:0] a_res;

    logic         adv_a;
    logic         adv_b;

    sum_xor_unit #(.N(N)) u_plain (
        .h (h),
        .c (c),
        .s (s_plain)
    );

    sum_xor_unit #(.N(N)) u_prim (
        .h (h_prim),
        .c (c_prim),
        .s (s_prim)
    );

    // A carry out of the primed path (or of its compression) means a+b >= M.
    assign sel   = c_prim[N-1] | ovf;
    assign a_res = a_sel ? a_prim : a_plain;

    assign adv_b    = !out_valid | out_ready;
    assign adv_a    = !va | adv_b;
    assign in_ready = adv_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            va            <= 1'b0;
            a_plain       <= '0;
            a_prim        <= '0;
            a_sel         <= 1'b0;
            out_valid     <= 1'b0;
            s             <= '0;
            out_range_err <= 1'b0;
        end else begin
            if (adv_a) begin
                va      <= in_valid;
                a_plain <= s_plain;
                a_prim  <= s_prim;
                a_sel   <= sel;
            end
            if (adv_b) begin
                out_valid     <= va;
                s             <= a_res;
                out_range_err <= (a_res >= MOD);
            end
        end
    end

endmodule

// File: tb/tb_modular_sum_stage.sv
// Randomized and directed bench for modular_sum_stage against an operand-level reference model.
module tb_modular_sum_stage;
    import adder_pkg::*;

    localparam int N = DEF_N;
    localparam int K = DEF_K;
    localparam int M = DEF_M;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] h, c, h_prim, c_prim;
    logic         ovf;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         out_range_err;

    modular_sum_stage #(.N(N), .K(K)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .h             (h),
        .c             (c),
        .h_prim        (h_prim),
        .c_prim        (c_prim),
        .ovf           (ovf),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .s             (s),
        .out_range_err (out_range_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    int q_s[$];
    int q_e[$];
    int q_cyc[$];

    logic held     = 1'b0;
    int   held_s   = 0;
    int   held_e   = 0;
    logic lat_chk  = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Golden upstream: plain half-sum/carries, and carry-save compression of a+b+K.
    function automatic void prep(input int a, input int b,
                                 output logic [N-1:0] oh, output logic [N-1:0] oc,
                                 output logic [N-1:0] ohp, output logic [N-1:0] ocp,
                                 output logic oov);
        int x, y, mj, msk;
        oh = N'(a ^ b);
        mj = (a & b) | (a & K) | (b & K);
        x  = (a ^ b ^ K) & ((1 << N) - 1);
        y  = (mj << 1) & ((1 << N) - 1);
        oov = 1'((mj >> (N - 1)) & 1);
        ohp = N'(x ^ y);
        for (int i = 0; i < N; i++) begin
            msk = (2 << i) - 1;
            oc[i]  = 1'((((a & msk) + (b & msk)) >> (i + 1)) & 1);
            ocp[i] = 1'((((x & msk) + (y & msk)) >> (i + 1)) & 1);
        end
    endfunction

    function automatic int ref_s(input int a, input int b);
        int t;
        t = a + b;
        return (t >= M) ? (t + K) % (1 << N) : t % (1 << N);
    endfunction

    task automatic cycle(input logic v, input int a, input int b, input logic rdy,
                         input logic rst, output logic acc);
        logic [N-1:0] th, tc, thp, tcp;
        logic tov;
        int r;
        @(posedge clk);
        #1;
        prep(a, b, th, tc, thp, tcp, tov);
        reset     = rst;
        in_valid  = v;
        h         = th;
        c         = tc;
        h_prim    = thp;
        c_prim    = tcp;
        ovf       = tov;
        out_ready = rdy;
        @(negedge clk);
        cyc++;
        acc = 1'b0;
        if (held) begin
            check("hold_s", int'(s), held_s);
            check("hold_err", int'(out_range_err), held_e);
        end
        check("in_ready", int'(in_ready), (q_s.size() == 2 && !rdy) ? 0 : 1);
        if (out_valid && out_ready) begin
            if (q_s.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                check("s", int'(s), q_s.pop_front());
                check("range_err", int'(out_range_err), q_e.pop_front());
                r = q_cyc.pop_front();
                if (lat_chk) check("latency", cyc - r, 2);
            end
        end
        if (v && in_ready) begin
            r = ref_s(a, b);
            q_s.push_back(r);
            q_e.push_back((r >= M) ? 1 : 0);
            q_cyc.push_back(cyc);
            acc = 1'b1;
        end
        held   = out_valid && !out_ready;
        held_s = int'(s);
        held_e = int'(out_range_err);
        if (rst) begin
            q_s.delete();
            q_e.delete();
            q_cyc.delete();
            held = 1'b0;
        end
    endtask

    task automatic drain(input int bound);
        logic acc;
        int n;
        n = 0;
        while (q_s.size() != 0 && n < bound) begin
            cycle(1'b0, 0, 0, 1'b1, 1'b0, acc);
            n++;
        end
        if (q_s.size() != 0) check("drain_timeout", q_s.size(), 0);
    endtask

    task automatic send_one(input int a, input int b);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, a, b, 1'b1, 1'b0, acc);
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        drain(20);
    endtask

    int da[6] = '{10, 20, 23, 0, 23, 56};
    int db[6] = '{5, 10, 1, 0, 23, 59};

    initial begin
        logic acc;
        int idx, n, ta, tb;
        logic [3:0] rpat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        h = '0; c = '0; h_prim = '0; c_prim = '0; ovf = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state, one cycle after release.
        cycle(1'b0, 0, 0, 1'b0, 1'b0, acc);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_s", int'(s), 0);
        check("rst_err", int'(out_range_err), 0);
        check("rst_in_ready", int'(in_ready), 1);

        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) send_one(da[i], db[i]);
        lat_chk = 1'b0;

        // Back-to-back with out_ready pattern 1,0,0,1.
        rpat = 4'b1001;
        idx = 0;
        n = 0;
        while ((idx < 8 || q_s.size() != 0) && n < 200) begin
            cycle(idx < 8, (idx * 7 + 3) % M, (idx * 5 + 11) % M, rpat[n % 4], 1'b0, acc);
            if (acc) idx++;
            n++;
        end
        check("b2b_all_sent", idx, 8);
        check("b2b_drained", q_s.size(), 0);

        // Reset with two results in flight.
        cycle(1'b1, 4, 4, 1'b0, 1'b0, acc);
        cycle(1'b1, 9, 9, 1'b0, 1'b0, acc);
        cycle(1'b0, 0, 0, 1'b0, 1'b0, acc);
        check("inflight_two", q_s.size(), 2);
        check("full_in_ready", int'(in_ready), 0);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, acc);
        cycle(1'b0, 0, 0, 1'b1, 1'b0, acc);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_s", int'(s), 0);
        repeat (4) cycle(1'b0, 0, 0, 1'b1, 1'b0, acc);

        // Random in-range traffic with random valid/ready.
        idx = 0;
        n = 0;
        ta = int'($urandom_range(0, M - 1));
        tb = int'($urandom_range(0, M - 1));
        while ((idx < 10000 || q_s.size() != 0) && n < 60000) begin
            cycle(idx < 10000 && $urandom_range(0, 3) != 0, ta, tb,
                  $urandom_range(0, 3) != 0, 1'b0, acc);
            if (acc) begin
                idx++;
                ta = int'($urandom_range(0, M - 1));
                tb = int'($urandom_range(0, M - 1));
            end
            n++;
        end
        check("rand_all_sent", idx, 10000);
        check("rand_drained", q_s.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/modular_sum_stage.md
# modular_sum_stage

Final stage of the modulo (2^N − K) adder. It consumes the half-sum and prefix-carry vectors of the plain path (a+b) and the primed path (a+b+K), and forms both candidate sums. It selects the reduced result and delivers it through a 2-deep stall-able pipeline with valid/ready handshakes. It sits directly downstream of the parallel-prefix stage.

## Interface
- N, 7, operand/result width
- K, 104, modulus correction constant; modulus M = 2^N − K (default M = 24); must satisfy 0 < K < 2^N
- clk  in  1  rising-edge clock; the block uses one clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream vectors valid
- in_ready  out  1  stage can accept this cycle
- h  in  N  plain half-sum a^b
- c  in  N  plain prefix carries; c[i] = carry out of bit i
- h_prim  in  N  primed half-sum from carry-save of a+b+K
- c_prim  in  N  primed prefix carries
- ovf  in  1  carry-save overflow bit of the a+b+K compression
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  N  (a+b) mod M
- out_range_err  out  1  selected result ≥ M (upstream operands out of range)

## Operation
- Candidate sums:
  - s_plain = h ^ {c[N-2:0],1'b0}
  - s_prim = h_prim ^ {c_prim[N-2:0],1'b0}
- Select: sel = c_prim[N-1] | ovf. sel=1 means a+b ≥ M, and the result is s_prim; otherwise the result is s_plain.
- Stage A registers s_plain, s_prim, sel and vA on input handshake (in_valid & in_ready).
- Stage B registers s = sel ? s_prim : s_plain and out_range_err = (s ≥ M), and sets out_valid.
- All arithmetic is modulo 2^N. The final carry out of the plain path is ignored. out_range_err is the only check.
- Flow control:
  - advB = !out_valid | out_ready
  - advA = !vA | advB
  - in_ready = advA
- Stage B load: when advB, load from A and set out_valid = vA.
- Stage A load: when advA, load from the inputs and set vA = in_valid.
- Bubbles collapse: an empty stage A or B is refilled even while the downstream is stalled.
- Held outputs: while out_valid & !out_ready, s and out_range_err are held stable and nothing is lost or duplicated.
- Reset values:
  - out_valid=0, s=0, out_range_err=0
  - vA=0, stage A data=0
  - in_ready=1 in the cycle after reset deasserts
- Reset mid-operation discards all in-flight results. No output handshake occurs for them.

## Timing
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput is 1 result per cycle.
- in_ready depends combinationally on out_ready through advB. This is the only comb path input→output. Data paths are fully registered.
- Simultaneous events: in the same cycle as out_valid & out_ready, the stage accepts new input and advances A→B, with no bubble.
- Back-pressure: with out_ready low for T cycles, at most 2 results are buffered. in_ready falls once both stages are full and rises the cycle out_ready is sampled high.
- Reset takes priority over the handshake in the same cycle.

## Structure
- Shared package adder_pkg holds:
  - default N, K
  - derived M = 2^N − K
  - width typedef word_t
  - a function computing mod-M reference sums for benches
- Sub-module sum_xor_unit: combinational h ^ (carry << 1), N-bit. It is instantiated twice, for the plain and primed paths.
- The top holds the select logic, the two pipeline registers and the handshake.

## Test plan
The bench derives h/c/h_prim/c_prim/ovf from operands a, b with a golden preprocessing+prefix model; N=7, K=104, M=24.
- a=10, b=5, out_ready=1 → s=15, out_range_err=0, out_valid exactly 2 cycles after handshake.
- a=20, b=10 → s=6 (sel=1). a=23, b=1 → s=0 (a+b+K = 128 exactly). a=0, b=0 → s=0.
- a=23, b=23 → s=22. a=56, b=59 (out of range) → out_range_err=1.
- Back-to-back 8 inputs with out_ready toggled 1,0,0,1,… → results in order, none dropped/duplicated, s stable while stalled, in_ready low only when both stages full.
- Assert reset with 2 results in flight → out_valid=0, s=0 the next cycle; no stale result appears after reset release.
- Random 10k pairs a, b < M with random in_valid/out_ready → every s equals (a+b) mod M, out_range_err never set.
